// File: rtl/data_mem_responder.sv
// Word-wide memory responder for the data-cache miss path: one request at a time, fixed access latency.
// Optional `define MEM_WR_ACK_EN makes writes return an acknowledge response carrying the merged word.
module data_mem_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024,
   parameter int LATENCY    = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic                    req_we_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] req_be_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [DATA_WIDTH-1:0]   resp_rdata_o,
   output logic                    busy_o,
   output logic [CNT_WIDTH-1:0]    req_count_o
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int NB    = DATA_WIDTH / 8;
   localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                  state_reg, state_next;
   logic [LAT_W-1:0]        lat_cnt_reg, lat_cnt_next;
   logic [IDX_W-1:0]        idx_reg;
   logic                    we_reg;
   logic [CNT_WIDTH-1:0]    count_reg;
   logic [DATA_WIDTH-1:0]   rdata_reg;
   logic [DATA_WIDTH-1:0]   mem_reg [DEPTH];

   logic                    accept;
   logic                    load_rdata;
   logic [IDX_W-1:0]        req_idx;
   logic [NB-1:0]           byte_we;
   logic                    unused_bits;

   // Word index only; byte offset and high address bits fold away so addresses wrap modulo DEPTH.
   assign req_idx = req_addr_i[IDX_W+1:2];

`ifdef MEM_WR_ACK_EN
   assign unused_bits = ^{req_addr_i[1:0], req_addr_i[ADDR_WIDTH-1:IDX_W+2], we_reg};
`else
   assign unused_bits = ^{req_addr_i[1:0], req_addr_i[ADDR_WIDTH-1:IDX_W+2]};
`endif

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_byte_we
         assign byte_we[gi] = accept & req_we_i & req_be_i[gi];
      end
   endgenerate

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_reg   <= IDLE;
         lat_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         lat_cnt_reg <= lat_cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      lat_cnt_next = lat_cnt_reg;
      accept       = 1'b0;
      load_rdata   = 1'b0;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      case (state_reg)
         IDLE: begin
            req_ready_o = 1'b1;
            // Reset is asynchronous, so gate acceptance to keep a request from slipping into memory during it.
            if (req_valid_i && !rst_i) begin
               accept       = 1'b1;
               lat_cnt_next = LAT_LOAD;
               state_next   = WAIT;
            end
         end
         WAIT: begin
            if (lat_cnt_reg == '0) begin
`ifdef MEM_WR_ACK_EN
               load_rdata = 1'b1;
               state_next = RESP;
`else
               if (we_reg) begin
                  state_next = IDLE;
               end else begin
                  load_rdata = 1'b1;
                  state_next = RESP;
               end
`endif
            end else begin
               lat_cnt_next = lat_cnt_reg - 1'b1;
            end
         end
         RESP: begin
            resp_valid_o = 1'b1;
            if (resp_ready_i) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_reg   <= '0;
         we_reg    <= 1'b0;
         count_reg <= '0;
         rdata_reg <= '0;
      end else begin
         if (accept) begin
            idx_reg <= req_idx;
            we_reg  <= req_we_i;
            if (count_reg != '1) begin
               count_reg <= count_reg + 1'b1;
            end
         end
         if (load_rdata) begin
            rdata_reg <= mem_reg[idx_reg];
         end
      end
   end

   // Storage is deliberately not reset; writes commit at the acceptance edge.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB; b++) begin
         if (byte_we[b]) begin
            mem_reg[req_idx][b*8 +: 8] <= req_wdata_i[b*8 +: 8];
         end
      end
   end

   assign busy_o       = (state_reg != IDLE);
   assign resp_rdata_o = rdata_reg;
   assign req_count_o  = count_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
// Honours `define MEM_WR_ACK_EN to expect write acknowledge responses.
module tb_data_mem_responder;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 1024;
   localparam int LAT   = 4;
   localparam int CW    = 2;
`ifdef MEM_WR_ACK_EN
   localparam bit WR_ACK = 1'b1;
`else
   localparam bit WR_ACK = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid_i = 1'b0;
   logic          req_ready_o;
   logic          req_we_i = 1'b0;
   logic [AW-1:0] req_addr_i = '0;
   logic [DW-1:0] req_wdata_i = '0;
   logic [3:0]    req_be_i = '0;
   logic          resp_valid_o;
   logic          resp_ready_i = 1'b0;
   logic [DW-1:0] resp_rdata_o;
   logic          busy_o;
   logic [CW-1:0] req_count_o;

   always #5 clk = ~clk;

   data_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .LATENCY(LAT), .CNT_WIDTH(CW)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_rdata_o(resp_rdata_o),
      .busy_o(busy_o), .req_count_o(req_count_o)
   );

   int n_vec = 0;
   int n_err = 0;
   int n_txn = 0;

   logic [31:0] model_mem [DEPTH];
   bit          model_valid [DEPTH];
   int          model_accepted = 0;

   function automatic logic [CW-1:0] exp_count();
      int sat;
      sat = (1 << CW) - 1;
      return CW'((model_accepted > sat) ? sat : model_accepted);
   endfunction

   task automatic model_apply(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic [31:0] exp_word);
      int idx;
      logic [31:0] mask;
      idx  = int'((addr / 4) % DEPTH);
      mask = 0;
      for (int b = 0; b < 4; b++) if (be[b]) mask = mask + (32'hFF << (8 * b));
      if (we) begin
         model_mem[idx]   = (model_mem[idx] & ~mask) | (wdata & mask);
         model_valid[idx] = 1'b1;
      end
      model_accepted++;
      exp_word = model_mem[idx];
   endtask

   // Drives one complete transaction and reports what was observed; callers do the checking.
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input int stall,
                          output bit rdy_before, output int lat, output bit resp_seen,
                          output logic [31:0] rdata, output bit stable, output bit idle_after,
                          output logic [CW-1:0] cnt);
      @(negedge clk);
      rdy_before  = req_ready_o;
      req_valid_i = 1'b1;
      req_we_i    = we;
      req_addr_i  = addr;
      req_wdata_i = wdata;
      req_be_i    = be;
      @(posedge clk);
      @(negedge clk);
      req_valid_i = 1'b0;
      req_we_i    = 1'($urandom);
      req_addr_i  = $urandom;
      req_wdata_i = $urandom;
      req_be_i    = 4'($urandom);
      lat = 0;
      while (busy_o && !resp_valid_o && lat < 50) begin
         lat++;
         @(negedge clk);
      end
      resp_seen = resp_valid_o;
      rdata     = resp_rdata_o;
      stable    = 1'b1;
      if (resp_seen) begin
         repeat (stall) begin
            @(negedge clk);
            if (!resp_valid_o || resp_rdata_o !== rdata || req_ready_o) stable = 1'b0;
         end
         resp_ready_i = 1'b1;
         @(negedge clk);
         resp_ready_i = 1'b0;
      end
      idle_after = req_ready_o && !resp_valid_o && !busy_o;
      cnt        = req_count_o;
      n_txn++;
      $display("txn %0d we=%0d addr=%h wdata=%h be=%h lat=%0d resp=%0d rdata=%h cnt=%0d",
               n_txn, we, addr, wdata, be, lat, resp_seen, rdata, cnt);
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      model_accepted = 0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      n_vec++;
      if ({req_ready_o, resp_valid_o, busy_o} !== 3'b100) begin
         n_err++; $display("FAIL reset_flags: got %b want 100", {req_ready_o, resp_valid_o, busy_o});
      end
      n_vec++;
      if (resp_rdata_o !== 32'h0 || req_count_o !== '0) begin
         n_err++; $display("FAIL reset_values: rdata=%h cnt=%0d want 0/0", resp_rdata_o, req_count_o);
      end
      rst_i = 1'b0;
   endtask

   task automatic test_write_read();
      bit rb, rs, st, ia; int lat; logic [31:0] rd, ew; logic [CW-1:0] cnt;
      model_apply(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ew);
      run_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (rb !== 1'b1 || lat !== LAT || rs !== WR_ACK || ia !== 1'b1) begin
         n_err++; $display("FAIL write_timing: ready=%0d lat=%0d resp=%0d idle=%0d want 1/%0d/%0d/1",
                           rb, lat, rs, ia, LAT, WR_ACK);
      end
      if (WR_ACK) begin
         n_vec++;
         if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL write_ack_data: got %h want deadbeef", rd); end
      end
      n_vec++;
      if (cnt !== exp_count()) begin n_err++; $display("FAIL write_count: got %0d want %0d", cnt, exp_count()); end
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, ew);
      run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (lat !== LAT || rs !== 1'b1 || ia !== 1'b1) begin
         n_err++; $display("FAIL read_timing: lat=%0d resp=%0d idle=%0d want %0d/1/1", lat, rs, ia, LAT);
      end
      n_vec++;
      if (rd !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_data: got %h want deadbeef", rd); end
      n_vec++;
      if (cnt !== exp_count()) begin n_err++; $display("FAIL read_count: got %0d want %0d", cnt, exp_count()); end
   endtask

   task automatic test_byte_enable();
      bit rb, rs, st, ia; int lat; logic [31:0] rd, ew; logic [CW-1:0] cnt;
      model_apply(1'b1, 32'h10, 32'h11223344, 4'b0101, ew);
      run_txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0, rb, lat, rs, rd, st, ia, cnt);
      if (WR_ACK) begin
         n_vec++;
         if (rd !== 32'hDE22BE44) begin n_err++; $display("FAIL be_ack_data: got %h want de22be44", rd); end
      end
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, ew);
      run_txn(1'b0, 32'h10, 32'hFFFFFFFF, 4'hF, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (rd !== 32'hDE22BE44) begin n_err++; $display("FAIL be_merge: got %h want de22be44", rd); end
      model_apply(1'b1, 32'h10, 32'h99999999, 4'h0, ew);
      run_txn(1'b1, 32'h10, 32'h99999999, 4'h0, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (lat !== LAT || cnt !== exp_count()) begin
         n_err++; $display("FAIL be_zero: lat=%0d cnt=%0d want %0d/%0d", lat, cnt, LAT, exp_count());
      end
   endtask

   task automatic test_backpressure();
      bit rb, rs, st, ia; int lat; logic [31:0] rd, ew; logic [CW-1:0] cnt;
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, ew);
      run_txn(1'b0, 32'h10, 32'h0, 4'h0, 3, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (st !== 1'b1 || ia !== 1'b1) begin
         n_err++; $display("FAIL backpressure: stable=%0d idle=%0d want 1/1", st, ia);
      end
      n_vec++;
      if (rd !== ew) begin n_err++; $display("FAIL backpressure_data: got %h want %h", rd, ew); end
   endtask

   task automatic test_wrap_and_saturation();
      bit rb, rs, st, ia; int lat; logic [31:0] rd, ew; logic [CW-1:0] cnt;
      model_apply(1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, ew);
      run_txn(1'b1, 32'h1010, 32'hCAFEF00D, 4'hF, 0, rb, lat, rs, rd, st, ia, cnt);
      model_apply(1'b0, 32'h10, 32'h0, 4'h0, ew);
      run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (rd !== 32'hCAFEF00D) begin n_err++; $display("FAIL wrap: got %h want cafef00d", rd); end
      pulse_reset();
      for (int i = 1; i <= 5; i++) begin
         model_apply(1'b0, 32'h10, 32'h0, 4'h0, ew);
         run_txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rb, lat, rs, rd, st, ia, cnt);
         n_vec++;
         if (cnt !== exp_count()) begin
            n_err++; $display("FAIL saturation_%0d: got %0d want %0d", i, cnt, exp_count());
         end
      end
   endtask

   task automatic test_reset_mid_flight();
      bit rb, rs, st, ia; int lat; logic [31:0] rd, ew; logic [CW-1:0] cnt;
      for (int k = 0; k < 2; k++) begin
         // k=0: write interrupted (must stay committed); k=1: read interrupted (response dropped)
         if (k == 0) model_apply(1'b1, 32'h20, 32'h5A5AA5A5, 4'hF, ew);
         @(negedge clk);
         req_valid_i = 1'b1; req_we_i = (k == 0); req_addr_i = 32'h20;
         req_wdata_i = 32'h5A5AA5A5; req_be_i = 4'hF;
         @(posedge clk);
         @(negedge clk);
         req_valid_i = 1'b0;
         @(posedge clk);
         @(posedge clk);
         #1 rst_i = 1'b1;
         #1;
         n_vec++;
         if ({busy_o, resp_valid_o, req_ready_o} !== 3'b001 || req_count_o !== '0 || resp_rdata_o !== 32'h0) begin
            n_err++; $display("FAIL async_reset_%0d: flags=%b cnt=%0d rdata=%h want 001/0/0",
                              k, {busy_o, resp_valid_o, req_ready_o}, req_count_o, resp_rdata_o);
         end
         @(negedge clk);
         rst_i = 1'b0;
         model_accepted = 0;
      end
      model_apply(1'b0, 32'h20, 32'h0, 4'h0, ew);
      run_txn(1'b0, 32'h20, 32'h0, 4'h0, 0, rb, lat, rs, rd, st, ia, cnt);
      n_vec++;
      if (rd !== 32'h5A5AA5A5 || cnt !== exp_count()) begin
         n_err++; $display("FAIL post_reset_read: rdata=%h cnt=%0d want 5a5aa5a5/%0d", rd, cnt, exp_count());
      end
   endtask

   task automatic test_random();
      bit rb, rs, st, ia, we; int lat, idx, stall; logic [31:0] rd, ew, addr, wdata; logic [3:0] be;
      logic [CW-1:0] cnt;
      for (int t = 0; t < 60; t++) begin
         idx   = int'($urandom_range(40, 47));
         addr  = ($urandom & 32'hFFFF_F000) | (32'(idx) << 2) | ($urandom & 32'h3);
         we    = 1'($urandom);
         wdata = $urandom;
         be    = 4'($urandom);
         stall = int'($urandom_range(0, 3));
         if (!model_valid[idx]) begin we = 1'b1; be = 4'hF; end
         model_apply(we, addr, wdata, be, ew);
         run_txn(we, addr, wdata, be, stall, rb, lat, rs, rd, st, ia, cnt);
         n_vec++;
         if (rb !== 1'b1 || lat !== LAT || rs !== (!we || WR_ACK) || st !== 1'b1 || ia !== 1'b1) begin
            n_err++; $display("FAIL rand_%0d_protocol: ready=%0d lat=%0d resp=%0d stable=%0d idle=%0d",
                              t, rb, lat, rs, st, ia);
         end
         if (rs) begin
            n_vec++;
            if (rd !== ew) begin n_err++; $display("FAIL rand_%0d_data: got %h want %h", t, rd, ew); end
         end
         n_vec++;
         if (cnt !== exp_count()) begin
            n_err++; $display("FAIL rand_%0d_count: got %0d want %0d", t, cnt, exp_count());
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_enable();
      test_backpressure();
      test_wrap_and_saturation();
      test_reset_mid_flight();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Main-memory responder that sits on the memory side of the data cache and services its word requests. It accepts one request at a time over a valid/ready handshake and waits a fixed, parameterised latency to model DRAM/BRAM access. For reads, it returns data over a valid/ready response channel. Byte-enabled writes are supported, and the block keeps a saturating count of serviced requests for performance monitoring.

Parameters:
ADDR_WIDTH, 32, request address width (byte address)
DATA_WIDTH, 32, data word width; must be a multiple of 8
DEPTH, 1024, words of storage; power of two
LATENCY, 4, cycles from request acceptance to completion; >= 1
CNT_WIDTH, 16, width of req_count_o

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  responder can accept a request
req_we_i  in  1  1 = write, 0 = read
req_addr_i  in  ADDR_WIDTH  byte address; bits [1:0] ignored
req_wdata_i  in  DATA_WIDTH  write data
req_be_i  in  DATA_WIDTH/8  byte enables for writes
resp_valid_o  out  1  response data valid
resp_ready_i  in  1  requester accepts response
resp_rdata_o  out  DATA_WIDTH  response data
busy_o  out  1  high whenever the state is not IDLE
req_count_o  out  CNT_WIDTH  accepted-request count, saturating

Behaviour:
- Reset is asynchronous and active-high on rst_i; clock is clk_i.
- Reset values:
  - state = IDLE, latency counter = 0
  - req_ready_o = 1, resp_valid_o = 0, resp_rdata_o = 0, busy_o = 0, req_count_o = 0
  - Storage array is not reset; its contents survive rst_i.
- Handshakes while rst_i is high are ignored.
- Index = req_addr_i[2+log2(DEPTH)-1:2]. Upper address bits are dropped, so addresses wrap modulo DEPTH words.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready_o = 1.
  - Acceptance happens at edge E0 when req_valid_i & req_ready_o.
  - On acceptance: latch index and req_we_i; load counter with LATENCY-1; go to WAIT; increment req_count_o unless it is all-ones.
  - Write at E0: for each byte b with req_be_i[b] = 1, mem[index] byte b <= req_wdata_i byte b. Other bytes are unchanged.
- WAIT:
  - req_ready_o = 0.
  - If counter == 0: a read goes to RESP and loads resp_rdata_o <= mem[latched index]; a write goes to IDLE.
  - Otherwise, decrement the counter.
  - Net timing: state leaves WAIT at edge E_LATENCY. resp_valid_o is first high in the cycle after E_LATENCY; for LATENCY = 1 that is the cycle after E1.
- RESP:
  - resp_valid_o = 1, req_ready_o = 0; resp_rdata_o is held stable.
  - On resp_valid_o & resp_ready_i: go to IDLE.
  - Backpressure of any length is legal.
- Exactly one request is outstanding at a time. The earliest next acceptance is the cycle after the response handshake (read) or after E_LATENCY (write).
- resp_rdata_o holds its last value after the handshake until the next read completion.
- Read-after-write to the same index returns the merged word, because the write commits at E0.
- Reset asserted mid-WAIT or mid-RESP: outputs go immediately to their reset values and the in-flight response is discarded. A write accepted before the reset remains committed.
- req_be_i is ignored on reads. A write with req_be_i = 0 still consumes LATENCY cycles and is counted.

Optional Feature:
MEM_WR_ACK_EN
- Defined: writes also pass through RESP after WAIT. resp_valid_o asserts and resp_rdata_o = the merged word now stored at the index; the transaction completes on the resp handshake.
- Undefined: writes complete silently at E_LATENCY (WAIT -> IDLE) and resp_valid_o is never asserted for a write.

Test Plan:
1. LATENCY=4, macro undefined: write 0x10, 0xDEADBEEF, be 0xF -> req_ready_o low for 4 cycles then high, no resp_valid_o, req_count_o = 1.
2. Read 0x10 -> resp_valid_o high in the cycle after E4 with resp_rdata_o = 0xDEADBEEF; handshake returns to IDLE, req_count_o = 2.
3. Write 0x10, 0x11223344, be 0b0101, then read 0x10 -> 0xDE22BE44.
4. Hold resp_ready_i low for 3 cycles during a read response -> resp_valid_o and resp_rdata_o stable, req_ready_o low; raise resp_ready_i -> IDLE next cycle.
5. DEPTH=1024: write 0x1010 = 0xCAFEF00D, read 0x10 -> 0xCAFEF00D (wrap). CNT_WIDTH=2: after 5 requests, req_count_o = 3 (saturated).
6. Assert rst_i two cycles into WAIT for a read -> busy_o and resp_valid_o drop at once, req_count_o = 0; after release, read of the previously written word returns the correct data. With MEM_WR_ACK_EN, a write yields resp_valid_o with the merged word.
